mar_seq: RTL and testbench
==========================

Name: mar_seq

Overview:
Parametrised memory address register with a built-in access sequencer. Supports load, increment and decrement of the address. Runs read/write cycles against synchronous SRAM with a configurable number of wait states, and reports completion with a one-cycle ready pulse. Sits between the datapath bus and the memory interface, in the MAR's position in the SLC-3 datapath.

Parameters:
N, 16, address width in bits (≥ 2)
WAIT_STATES, 2, cycles CE held before data valid (≥ 1)
RESET_ADDR, 0, DOUT value after reset (N bits)

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  asynchronous, active-low reset
LD_MAR  in  1  load DIN into address register
INC_MAR  in  1  address + 1
DEC_MAR  in  1  address - 1
DIN  in  N  address from bus
MEM_RD  in  1  request read cycle at current address
MEM_WR  in  1  request write cycle at current address
DOUT  out  N  current address to memory
CE  out  1  memory chip enable, high during access
WE  out  1  write enable, high during write access only
R  out  1  one-cycle ready pulse at access completion
BUSY  out  1  high while an access is in progress (ACCESS or DONE)

Behaviour:
- Reset (Reset=0, asynchronous) sets DOUT=RESET_ADDR, CE=0, WE=0, R=0, BUSY=0, state=IDLE, wait counter=0.
- A reset that arrives mid-access aborts the access immediately. No R pulse is produced.
- Address ops apply only in IDLE.
  - Priority: LD_MAR > INC_MAR > DEC_MAR.
  - Each op takes effect on the next edge.
  - Outside IDLE, all three are ignored.
- Arithmetic is modulo 2^N.
  - INC at all-ones wraps to 0.
  - DEC at 0 wraps to all-ones.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If MEM_RD=1 or MEM_WR=1, go to ACCESS, load counter=WAIT_STATES-1, set CE=1, BUSY=1.
  - WE=1 only when MEM_WR=1 and MEM_RD=0. MEM_RD has priority when both are asserted, and the access proceeds as a read.
  - An address op in the same cycle as a request: the address op applies on that edge, and the access uses the updated address from its first CE cycle.
- ACCESS:
  - CE held for exactly WAIT_STATES cycles. WE is held constant.
  - Counter decrements each cycle. At counter==0, go to DONE, drop CE/WE, set R=1.
- DONE:
  - R=1 for exactly one cycle, BUSY=1.
  - Then go to IDLE with R=0, BUSY=0.
  - Requests arriving in DONE are ignored. The requester must re-assert in IDLE, so back-to-back accesses are separated by at least one IDLE cycle.
- Latency: request edge to R high = WAIT_STATES+1 cycles.
- MEM_RD/MEM_WR need not be held after acceptance. A deassert during ACCESS does not abort the access.
- DOUT is stable from the first CE cycle through DONE.

Optional Feature:
- Macro: MAR_SEQ_AUTOINC_EN.
- With the macro defined: on the ACCESS→DONE edge, DOUT increments by 1 (mod 2^N), so the address is already advanced when R is high. This supports block copies.
- Without the macro: DOUT is unchanged by accesses.

Test Plan:
- Reset=0 mid-ACCESS with DOUT=16'h1234, RESET_ADDR=0 -> DOUT=16'h0000, CE=0, R=0 immediately, without waiting for a clock; no R pulse afterwards.
- LD_MAR=1, DIN=16'hFFFF, then INC_MAR one cycle -> DOUT=16'h0000. Then DEC_MAR -> DOUT=16'hFFFF. Then LD_MAR+INC_MAR together with DIN=16'h0010 -> DOUT=16'h0010.
- DOUT=16'h3000, MEM_RD pulse 1 cycle, WAIT_STATES=2 -> CE=1 for exactly 2 cycles, WE=0, R=1 on cycle 3 only, BUSY high 3 cycles, DOUT=16'h3000 throughout.
- MEM_WR=1 and MEM_RD=1 same cycle -> read performed (WE=0 whole access). Then MEM_WR alone -> WE=1 exactly while CE=1.
- During ACCESS, LD_MAR=1 with DIN=16'hBEEF and MEM_RD re-pulsed -> DOUT unchanged, single access, one R pulse.
- With MAR_SEQ_AUTOINC_EN defined, DOUT=16'hFFFF, MEM_RD -> DOUT=16'h0000 in the R cycle. Without the macro -> DOUT stays 16'hFFFF.

Source files
------------

// File: rtl/mar_seq.sv
// Memory address register with an SRAM access sequencer (IDLE -> ACCESS -> DONE).
// Optional MAR_SEQ_AUTOINC_EN: advance DOUT by one as each access completes.
module mar_seq #(
    parameter int unsigned   N           = 16,
    parameter int unsigned   WAIT_STATES = 2,
    parameter logic [N-1:0]  RESET_ADDR  = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         LD_MAR,
    input  logic         INC_MAR,
    input  logic         DEC_MAR,
    input  logic [N-1:0] DIN,
    input  logic         MEM_RD,
    input  logic         MEM_WR,
    output logic [N-1:0] DOUT,
    output logic         CE,
    output logic         WE,
    output logic         R,
    output logic         BUSY
);

    localparam int unsigned CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   addr_op_c;
    logic           req_c;

    // Address update for IDLE: load beats increment beats decrement
    always_comb begin
        addr_op_c = DOUT;
        if (LD_MAR) begin
            addr_op_c = DIN;
        end else if (INC_MAR) begin
            addr_op_c = DOUT + N'(1);
        end else if (DEC_MAR) begin
            addr_op_c = DOUT - N'(1);
        end
    end

    assign req_c = MEM_RD | MEM_WR;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            DOUT  <= RESET_ADDR;
            CE    <= 1'b0;
            WE    <= 1'b0;
            R     <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DOUT <= addr_op_c;
                    R    <= 1'b0;
                    if (req_c) begin
                        state <= ACCESS;
                        cnt   <= CW'(WAIT_STATES - 1);
                        CE    <= 1'b1;
                        // A simultaneous read and write request runs as a read
                        WE    <= MEM_WR & ~MEM_RD;
                        BUSY  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        CE    <= 1'b0;
                        WE    <= 1'b0;
                        R     <= 1'b1;
`ifdef MAR_SEQ_AUTOINC_EN
                        DOUT  <= DOUT + N'(1);
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    R     <= 1'b0;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    CE    <= 1'b0;
                    WE    <= 1'b0;
                    R     <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mar_seq.sv
// Scoreboard bench for mar_seq: a cycle-counting reference model queues expected
// accesses, and a monitor checks each completed access when R is presented.
module tb_mar_seq;

    localparam int unsigned N  = 16;
    localparam int unsigned WS = 2;

    logic          Clk;
    logic          Reset;
    logic          LD_MAR, INC_MAR, DEC_MAR;
    logic [N-1:0]  DIN;
    logic          MEM_RD, MEM_WR;
    logic [N-1:0]  DOUT;
    logic          CE, WE, R, BUSY;

    mar_seq #(.N(N), .WAIT_STATES(WS), .RESET_ADDR(16'h0000)) dut (
        .Clk(Clk), .Reset(Reset),
        .LD_MAR(LD_MAR), .INC_MAR(INC_MAR), .DEC_MAR(DEC_MAR),
        .DIN(DIN), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .DOUT(DOUT), .CE(CE), .WE(WE), .R(R), .BUSY(BUSY)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [N-1:0] addr;
        logic         we;
        logic [N-1:0] raddr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: address register plus cycles until the sequencer is idle again
    logic [N-1:0] m_addr;
    int           m_busy;

`ifdef MAR_SEQ_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic ld, input logic inc, input logic dec,
                        input logic [N-1:0] din, input logic rd, input logic wr);
        exp_t e;
        LD_MAR = ld; INC_MAR = inc; DEC_MAR = dec; DIN = din; MEM_RD = rd; MEM_WR = wr;
        if (m_busy == 0) begin
            if (ld)       m_addr = din;
            else if (inc) m_addr = m_addr + 16'd1;
            else if (dec) m_addr = m_addr - 16'd1;
            if (rd || wr) begin
                e.addr  = m_addr;
                e.we    = wr && !rd;
                e.raddr = AUTOINC ? m_addr + 16'd1 : m_addr;
                q.push_back(e);
                m_busy  = WS + 1;
                if (AUTOINC) m_addr = m_addr + 16'd1;
            end
        end else begin
            m_busy--;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 0, 0);
    endtask

    // Monitor: tracks CE windows and scores each access when R is seen
    int           ce_cnt;
    logic [N-1:0] ce_addr;
    logic         ce_we, addr_bad, we_bad, prev_r;

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset) begin
            ce_cnt = 0; addr_bad = 0; we_bad = 0; prev_r = 0;
        end else begin
            check("we_outside_ce", 32'(WE & ~CE), 32'd0);
            check("busy", 32'(BUSY), 32'(CE | R));
            if (prev_r) check("r_single_cycle", 32'(R), 32'd0);
            if (CE) begin
                if (ce_cnt == 0) begin
                    ce_addr = DOUT;
                    ce_we   = WE;
                end else begin
                    if (DOUT !== ce_addr) addr_bad = 1;
                    if (WE !== ce_we)     we_bad   = 1;
                end
                ce_cnt++;
            end
            if (R) begin
                if (q.size() == 0) begin
                    check("unexpected_r", 32'(R), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("access_addr", 32'(ce_addr), 32'(e.addr));
                    check("access_we", 32'(ce_we), 32'(e.we));
                    check("ce_cycles", 32'(ce_cnt), 32'(WS));
                    check("addr_stable", 32'(addr_bad), 32'd0);
                    check("we_stable", 32'(we_bad), 32'd0);
                    check("dout_at_r", 32'(DOUT), 32'(e.raddr));
                end
                ce_cnt = 0; addr_bad = 0; we_bad = 0;
            end
            prev_r = R;
        end
    end

    initial begin
        logic [N-1:0] d;
        int           op;
        Reset = 1'b0;
        LD_MAR = 0; INC_MAR = 0; DEC_MAR = 0; DIN = '0; MEM_RD = 0; MEM_WR = 0;
        m_addr = 16'h0000;
        m_busy = 0;
        #22;
        check("rst_dout", 32'(DOUT), 32'h0);
        check("rst_ce", 32'(CE), 32'd0);
        check("rst_we", 32'(WE), 32'd0);
        check("rst_r", 32'(R), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Address ops and wrap-around
        step(1, 0, 0, 16'hFFFF, 0, 0);
        check("ld_ffff", 32'(DOUT), 32'hFFFF);
        step(0, 1, 0, 16'h0, 0, 0);
        check("inc_wrap", 32'(DOUT), 32'h0000);
        step(0, 0, 1, 16'h0, 0, 0);
        check("dec_wrap", 32'(DOUT), 32'hFFFF);
        step(1, 1, 0, 16'h0010, 0, 0);
        check("ld_over_inc", 32'(DOUT), 32'h0010);

        // Single read
        step(1, 0, 0, 16'h3000, 0, 0);
        step(0, 0, 0, 16'h0, 1, 0);
        check("rd_ce_first", 32'(CE), 32'd1);
        check("rd_we", 32'(WE), 32'd0);
        idle(WS + 2);

        // Read wins over write, then a plain write
        step(0, 0, 0, 16'h0, 1, 1);
        idle(WS + 2);
        step(0, 0, 0, 16'h0, 0, 1);
        check("wr_we", 32'(WE), 32'd1);
        idle(WS + 2);

        // Ops and requests during an access are ignored
        step(1, 0, 0, 16'h3000, 0, 0);
        step(0, 0, 0, 16'h0, 1, 0);
        step(1, 0, 0, 16'hBEEF, 1, 0);
        step(0, 1, 0, 16'h0, 1, 0);
        check("ld_ignored_busy", 32'(DOUT), 32'(m_addr));
        idle(WS + 2);

        // Completion at all-ones address
        step(1, 0, 0, 16'hFFFF, 0, 0);
        step(0, 0, 0, 16'h0, 1, 0);
        idle(WS + 2);
        check("after_ffff_access", 32'(DOUT), AUTOINC ? 32'h0000 : 32'hFFFF);

        // Reset mid-access aborts immediately, no R afterwards
        step(1, 0, 0, 16'h1234, 0, 0);
        step(0, 0, 0, 16'h0, 1, 0);
        step(0, 0, 0, 16'h0, 0, 0);
        Reset = 1'b0;
        #1;
        check("abort_dout", 32'(DOUT), 32'h0);
        check("abort_ce", 32'(CE), 32'd0);
        check("abort_r", 32'(R), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);
        q.delete();
        m_busy = 0;
        m_addr = 16'h0000;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        idle(WS + 4);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            d  = ($urandom_range(0, 3) == 0) ? 16'hFFFF :
                 ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            op = int'($urandom_range(0, 7));
            step(op == 1, op == 2 || op == 4, op == 3 || op == 4, d,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            if (m_busy == 0 && $urandom_range(0, 7) == 0)
                check("idle_dout", 32'(DOUT), 32'(m_addr));
        end
        for (int i = 0; i < 10 && m_busy != 0; i++) idle(1);
        idle(2);
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
